// File: rtl/range_pkg.sv
// rtl/range_pkg.sv - shared types for the range tracker
//   mode_t  : result selection latched at session start
//   state_t : session FSM states
package range_pkg;

  typedef enum logic [1:0] {
    MODE_RANGE = 2'd0,
    MODE_MAX   = 2'd1,
    MODE_MIN   = 2'd2,
    MODE_MID   = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/range_minmax_unit.sv
// rtl/range_minmax_unit.sv - combinational min/max fold with range and midpoint candidates
//   cur_min, cur_max : running extremes (WIDTH)
//   sample           : incoming sample (WIDTH)
//   next_min/max     : extremes after folding in sample
//   range_val        : next_max - next_min as unsigned WIDTH bits
//   mid_val          : floor((next_min + next_max) / 2)
module range_minmax_unit
  import range_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] next_min,
  output logic [WIDTH-1:0] next_max,
  output logic [WIDTH-1:0] range_val,
  output logic [WIDTH-1:0] mid_val
);

  logic             lt_min;
  logic             gt_max;
  logic [WIDTH:0]   sum;

  always_comb begin
    if (SIGNED != 0) begin
      lt_min = $signed(sample) < $signed(cur_min);
      gt_max = $signed(sample) > $signed(cur_max);
    end else begin
      lt_min = sample < cur_min;
      gt_max = sample > cur_max;
    end
    next_min = lt_min ? sample : cur_min;
    next_max = gt_max ? sample : cur_max;

    // max >= min always, so the wrapped difference is the exact unsigned range
    range_val = next_max - next_min;

    // one extra bit keeps the sum exact; dropping bit 0 is a floor shift
    if (SIGNED != 0)
      sum = {next_min[WIDTH-1], next_min} + {next_max[WIDTH-1], next_max};
    else
      sum = {1'b0, next_min} + {1'b0, next_max};
    mid_val = sum[WIDTH:1];
  end

endmodule

// File: rtl/range_tracker.sv
// rtl/range_tracker.sv - session-framed min/max tracker reporting range, max, min or midpoint
//   clock, reset_n   : rising-edge clock, async active-low reset
//   data_in          : sample, taken every cycle a session is open
//   go, finish       : session start / end (finish cycle sample included)
//   mode             : result selection, latched at session start
//   result           : held result of the last completed session
//   result_valid     : one-cycle pulse when result updates
//   sample_count     : saturating sample count of current/last session
//   busy             : session open
//   error            : sticky protocol error, cleared by a clean start
module range_tracker
  import range_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             go,
  input  logic             finish,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [CNT_W-1:0] sample_count,
  output logic             busy,
  output logic             error
);

  state_t           state;
  mode_t            mode_r;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] next_min;
  logic [WIDTH-1:0] next_max;
  logic [WIDTH-1:0] range_val;
  logic [WIDTH-1:0] mid_val;
  logic [WIDTH-1:0] result_sel;
  logic [CNT_W-1:0] count_inc;

  range_minmax_unit #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_minmax (
    .cur_min   (min_r),
    .cur_max   (max_r),
    .sample    (data_in),
    .next_min  (next_min),
    .next_max  (next_max),
    .range_val (range_val),
    .mid_val   (mid_val)
  );

  assign busy = (state == ACTIVE);

  always_comb begin
    count_inc = (sample_count == {CNT_W{1'b1}}) ? sample_count
                                                : sample_count + CNT_W'(1);
    case (mode_r)
      MODE_RANGE: result_sel = range_val;
      MODE_MAX:   result_sel = next_max;
      MODE_MIN:   result_sel = next_min;
      default:    result_sel = mid_val;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mode_r       <= MODE_RANGE;
      min_r        <= '0;
      max_r        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      sample_count <= '0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (finish) begin
            error <= 1'b1;
          end else if (go) begin
            state        <= ACTIVE;
            min_r        <= data_in;
            max_r        <= data_in;
            sample_count <= CNT_W'(1);
            mode_r       <= mode_t'(mode);
            error        <= 1'b0;
          end
        end
        ACTIVE: begin
          if (finish) begin
            // finish wins over a simultaneous go, which only flags an error
            min_r        <= next_min;
            max_r        <= next_max;
            sample_count <= count_inc;
            result       <= result_sel;
            result_valid <= 1'b1;
            state        <= IDLE;
            if (go)
              error <= 1'b1;
          end else if (go) begin
            min_r        <= data_in;
            max_r        <= data_in;
            sample_count <= CNT_W'(1);
            mode_r       <= mode_t'(mode);
            error        <= 1'b1;
          end else begin
            min_r        <= next_min;
            max_r        <= next_max;
            sample_count <= count_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
